// File: rtl/converter_i2f_arbiter.sv
// Round-robin arbiter sharing one int-to-float converter among NUM_REQ requesters.
// A single transaction is in flight at a time: accept, send, wait, ack, return.
module converter_i2f_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned GW      = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                   i_CLK,
  input  logic                   i_RST,
  input  logic [32*NUM_REQ-1:0]  i_REQ_A,
  input  logic [NUM_REQ-1:0]     i_REQ_STB,
  output logic [NUM_REQ-1:0]     o_REQ_ACK,
  output logic [31:0]            o_RSP_Z,
  output logic [NUM_REQ-1:0]     o_RSP_STB,
  input  logic [NUM_REQ-1:0]     i_RSP_ACK,
  output logic [31:0]            o_CVT_A,
  output logic                   o_CVT_A_STB,
  input  logic                   i_CVT_A_ACK,
  input  logic [31:0]            i_CVT_Z,
  input  logic                   i_CVT_Z_STB,
  output logic                   o_CVT_Z_ACK,
  output logic                   o_BUSY,
  output logic [GW-1:0]          o_GRANT,
  output logic [CNT_W-1:0]       o_XFER_CNT
);

  typedef enum logic [2:0] {
    S_IDLE, S_ACCEPT, S_SEND, S_WAIT, S_ZACK, S_RETURN
  } state_t;

  state_t               state, next_state;
  logic [GW-1:0]        r_last;
  logic [GW-1:0]        pick;
  logic [GW-1:0]        cand;
  logic                 pick_vld;
  logic [31:0]          r_data;
  logic [GW-1:0]        grant_d;
  logic [NUM_REQ-1:0]   req_ack_d;
  logic [NUM_REQ-1:0]   rsp_stb_d;
  logic                 cvt_a_stb_d;
  logic                 cvt_z_ack_d;
  logic                 busy_d;

  // Scan r_last+1 .. r_last+NUM_REQ (mod NUM_REQ); r_last itself is tried last.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = GW'((32'(r_last) + i) % NUM_REQ);
      if (!pick_vld && i_REQ_STB[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (pick_vld)              next_state = S_ACCEPT;
      S_ACCEPT:                            next_state = S_SEND;
      S_SEND:   if (i_CVT_A_ACK)           next_state = S_WAIT;
      S_WAIT:   if (i_CVT_Z_STB)           next_state = S_ZACK;
      S_ZACK:                              next_state = S_RETURN;
      S_RETURN: if (i_RSP_ACK[o_GRANT])    next_state = S_IDLE;
      default:                             next_state = S_IDLE;
    endcase
  end

  // Outputs are decoded from next_state so the registered copy lines up with the state.
  always_comb begin
    grant_d = o_GRANT;
    if (state == S_IDLE && pick_vld) grant_d = pick;
    req_ack_d   = '0;
    rsp_stb_d   = '0;
    if (next_state == S_ACCEPT) req_ack_d[grant_d] = 1'b1;
    if (next_state == S_RETURN) rsp_stb_d[grant_d] = 1'b1;
    cvt_a_stb_d = (next_state == S_SEND);
    cvt_z_ack_d = (next_state == S_ZACK);
    busy_d      = (next_state != S_IDLE);
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state       <= S_IDLE;
      r_last      <= GW'(NUM_REQ - 1);
      r_data      <= '0;
      o_GRANT     <= '0;
      o_REQ_ACK   <= '0;
      o_RSP_STB   <= '0;
      o_RSP_Z     <= '0;
      o_CVT_A     <= '0;
      o_CVT_A_STB <= 1'b0;
      o_CVT_Z_ACK <= 1'b0;
      o_BUSY      <= 1'b0;
      o_XFER_CNT  <= '0;
    end else begin
      state       <= next_state;
      o_GRANT     <= grant_d;
      o_REQ_ACK   <= req_ack_d;
      o_RSP_STB   <= rsp_stb_d;
      o_CVT_A_STB <= cvt_a_stb_d;
      o_CVT_Z_ACK <= cvt_z_ack_d;
      o_BUSY      <= busy_d;
      if (state == S_IDLE && pick_vld) r_data <= i_REQ_A[{pick, 5'b0} +: 32];
      if (state == S_ACCEPT) o_CVT_A <= r_data;
      if (state == S_WAIT && i_CVT_Z_STB) o_RSP_Z <= i_CVT_Z;
      if (state == S_RETURN && i_RSP_ACK[o_GRANT]) begin
        r_last     <= o_GRANT;
        o_XFER_CNT <= o_XFER_CNT + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_converter_i2f_arbiter.sv
// Bench for converter_i2f_arbiter: converter model, requester models with a
// round-robin scoreboard, directed vector table and multi-cycle sequences.
module tb_converter_i2f_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned GW = 2;
  localparam int unsigned CW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [32*N-1:0] req_a;
  logic [N-1:0]    req_stb, req_ack, rsp_stb, rsp_ack, rsp_junk, rsp_ack_bus;
  logic [31:0]     rsp_z, cvt_a, cvt_z;
  logic            cvt_a_stb, cvt_a_ack, cvt_z_stb, cvt_z_ack, busy;
  logic [GW-1:0]   grant;
  logic [CW-1:0]   xfer_cnt;

  assign rsp_ack_bus = rsp_ack | rsp_junk;
  always #5 clk = ~clk;

  converter_i2f_arbiter #(.NUM_REQ(N), .GW(GW), .CNT_W(CW)) dut (
    .i_CLK(clk), .i_RST(rst), .i_REQ_A(req_a), .i_REQ_STB(req_stb),
    .o_REQ_ACK(req_ack), .o_RSP_Z(rsp_z), .o_RSP_STB(rsp_stb), .i_RSP_ACK(rsp_ack_bus),
    .o_CVT_A(cvt_a), .o_CVT_A_STB(cvt_a_stb), .i_CVT_A_ACK(cvt_a_ack),
    .i_CVT_Z(cvt_z), .i_CVT_Z_STB(cvt_z_stb), .o_CVT_Z_ACK(cvt_z_ack),
    .o_BUSY(busy), .o_GRANT(grant), .o_XFER_CNT(xfer_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Exact for |x| < 2^24, which is all the bench ever converts.
  function automatic logic [31:0] ref_i2f(input logic [31:0] x);
    logic [31:0] m;
    int p;
    if (x == 32'd0) return 32'd0;
    m = x[31] ? -x : x;
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    return {x[31], 8'(127 + p), 23'(m << (23 - p))};
  endfunction

  // ---------------- converter model ----------------
  int  cph = 0, ccnt = 0;
  int  a_wait_cfg = 0, lat_cfg = 1;
  bit  rand_cvt = 1'b0;
  logic [31:0] cvt_hold;

  initial begin
    cvt_a_ack = 1'b0; cvt_z_stb = 1'b0; cvt_z = '0; cvt_hold = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cvt_a_ack = 1'b0; cvt_z_stb = 1'b0; cph = 0;
      end else begin
        if (cph == 5) begin cvt_z_stb = 1'b0; cph = 0; end
        if (cph == 4 && cvt_z_ack) cph = 5;
        if (cph == 0 && cvt_a_stb) begin
          ccnt = rand_cvt ? int'($urandom_range(0, 2)) : a_wait_cfg;
          cph = 1;
        end
        if (cph == 1) begin
          if (ccnt == 0) begin cvt_a_ack = 1'b1; cvt_hold = cvt_a; cph = 2; end
          else ccnt--;
        end else if (cph == 2) begin
          cvt_a_ack = 1'b0;
          ccnt = rand_cvt ? int'($urandom_range(0, 4)) : lat_cfg;
          cph = 3;
        end
        if (cph == 3) begin
          if (ccnt == 0) begin cvt_z_stb = 1'b1; cvt_z = ref_i2f(cvt_hold); cph = 4; end
          else ccnt--;
        end
      end
    end
  end

  // ---------------- requesters + scoreboard ----------------
  logic [31:0] qmem [N][64];
  int  qh [N], qt [N];
  int  stall_cfg [N], stall_cnt [N];
  bit  drop_pend [N];
  bit  rand_stall = 1'b0;
  int  sb_last, cur_g, eg, kk, xfers, rsp_cycles;
  bit  outstanding;
  logic [31:0] cur_z;
  logic [N-1:0] exp_oh;
  int  log_g [$];
  logic [31:0] log_z [$];
  int  log_rc [$];

  task automatic push(input int k, input logic [31:0] v);
    qmem[k][qt[k] % 64] = v;
    qt[k]++;
  endtask

  initial begin
    req_stb = '0; req_a = '0; rsp_ack = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        req_stb = '0; rsp_ack = '0; sb_last = N - 1; outstanding = 1'b0; xfers = 0; cur_g = 0;
        for (int k = 0; k < N; k++) begin
          drop_pend[k] = 1'b0; qh[k] = 0; qt[k] = 0; stall_cnt[k] = stall_cfg[k];
        end
        continue;
      end
      // result handshake completed on the previous rising edge
      if (rsp_ack != '0) begin
        rsp_ack = '0; xfers++; sb_last = cur_g; outstanding = 1'b0;
        log_g.push_back(cur_g); log_z.push_back(rsp_z); log_rc.push_back(rsp_cycles);
        chk("xfer_cnt", 32'(xfer_cnt), 32'(xfers % 16));
        chk("busy_after_return", 32'(busy), 32'd0);
      end
      for (int k = 0; k < N; k++)
        if (drop_pend[k]) begin drop_pend[k] = 1'b0; req_stb[k] = 1'b0; end
      if (req_ack != '0) begin
        eg = -1;
        for (int i = 1; i <= N; i++) begin
          kk = (sb_last + i) % N;
          if (eg < 0 && req_stb[kk]) eg = kk;
        end
        exp_oh = '0;
        if (eg >= 0) exp_oh[eg] = 1'b1;
        chk("req_ack_onehot", 32'(req_ack), 32'(exp_oh));
        chk("grant", 32'(grant), eg);
        chk("ack_while_busy", 32'(outstanding), 32'd0);
        for (int k = 0; k < N; k++) if (req_ack[k]) drop_pend[k] = 1'b1;
        cur_g = (eg >= 0) ? eg : 0;
        cur_z = ref_i2f(req_a[32*cur_g +: 32]);
        outstanding = 1'b1; rsp_cycles = 0;
      end
      if (rsp_stb != '0) begin
        rsp_cycles++;
        exp_oh = '0; exp_oh[cur_g] = 1'b1;
        chk("rsp_stb_onehot", 32'(rsp_stb), 32'(exp_oh));
        chk("rsp_z", rsp_z, cur_z);
        chk("no_ack_in_return", 32'(req_ack), 32'd0);
      end
      for (int k = 0; k < N; k++)
        if (rsp_stb[k]) begin
          if (stall_cnt[k] == 0) begin
            rsp_ack[k] = 1'b1;
            stall_cnt[k] = rand_stall ? int'($urandom_range(0, 3)) : stall_cfg[k];
          end else stall_cnt[k]--;
        end
      for (int k = 0; k < N; k++)
        if (!req_stb[k] && qh[k] != qt[k]) begin
          req_a[32*k +: 32] = qmem[k][qh[k] % 64];
          qh[k]++;
          req_stb[k] = 1'b1;
        end
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    @(posedge clk); #2 rst = 1'b1;
    log_g.delete(); log_z.delete(); log_rc.delete();
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk);
  endtask

  task automatic wait_log(input int n, input int budget, input string name);
    int c = 0;
    while (log_g.size() < n && c < budget) begin @(posedge clk); c++; end
    chk({name, "_done"}, 32'(log_g.size()), 32'(n));
  endtask

  typedef struct {
    logic [3:0]       mask;
    logic [3:0][31:0] op;
    int               reps;
    int               n;
    logic [7:0][1:0]  eg;
    logic [7:0][31:0] ez;
  } vec_t;

  vec_t tbl [4];
  logic [3:0][31:0] ez4;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rsp_junk = '0;
    for (int r = 0; r < 4; r++) begin
      tbl[r].mask = '0; tbl[r].op = '0; tbl[r].reps = 1; tbl[r].n = 1;
      tbl[r].eg = '0; tbl[r].ez = '0;
    end
    tbl[0].mask = 4'b0001; tbl[0].op[0] = 32'd1; tbl[0].ez[0] = 32'h3F800000;
    tbl[1].mask = 4'b0101; tbl[1].op[0] = 32'hFFFFFFFF; tbl[1].op[2] = 32'd100; tbl[1].n = 2;
    tbl[1].eg[1] = 2'd2; tbl[1].ez[0] = 32'hBF800000; tbl[1].ez[1] = 32'h42C80000;
    tbl[2].mask = 4'b1111; tbl[2].op[0] = 32'd0; tbl[2].op[1] = 32'd2; tbl[2].op[2] = 32'd3;
    tbl[2].op[3] = 32'd1; tbl[2].reps = 2; tbl[2].n = 8;
    ez4[0] = 32'h00000000; ez4[1] = 32'h40000000; ez4[2] = 32'h40400000; ez4[3] = 32'h3F800000;
    for (int i = 0; i < 8; i++) begin tbl[2].eg[i] = 2'(i % 4); tbl[2].ez[i] = ez4[i % 4]; end
    tbl[3].mask = 4'b0010; tbl[3].op[1] = 32'd3; tbl[3].eg[0] = 2'd1; tbl[3].ez[0] = 32'h40400000;

    // reset values
    @(posedge clk); @(negedge clk);
    chk("rst_req_ack", 32'(req_ack), 0);   chk("rst_rsp_stb", 32'(rsp_stb), 0);
    chk("rst_cvt_a_stb", 32'(cvt_a_stb), 0); chk("rst_cvt_z_ack", 32'(cvt_z_ack), 0);
    chk("rst_busy", 32'(busy), 0);         chk("rst_grant", 32'(grant), 0);
    chk("rst_xfer_cnt", 32'(xfer_cnt), 0); chk("rst_rsp_z", rsp_z, 0);
    chk("rst_cvt_a", cvt_a, 0);
    @(posedge clk); #2 rst = 1'b0;

    // directed vector table, each record from a fresh reset
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int k = 0; k < 4; k++)
        if (tbl[r].mask[k]) for (int j = 0; j < tbl[r].reps; j++) push(k, tbl[r].op[k]);
      wait_log(tbl[r].n, 300, $sformatf("t%0d", r));
      for (int i = 0; i < tbl[r].n && i < log_g.size(); i++) begin
        chk($sformatf("t%0d_grant%0d", r, i), 32'(log_g[i]), 32'(tbl[r].eg[i]));
        chk($sformatf("t%0d_z%0d", r, i), log_z[i], tbl[r].ez[i]);
      end
      @(negedge clk);
      chk($sformatf("t%0d_idle", r), 32'(busy), 0);
      chk($sformatf("t%0d_cnt", r), 32'(xfer_cnt), 32'(tbl[r].n % 16));
    end

    // response stall with stray acks on other bits
    stall_cfg[3] = 10;
    do_reset();
    push(3, 32'd5);
    for (int c = 0; c < 50 && !rsp_stb[3]; c++) @(posedge clk);
    push(0, 32'd7);
    rsp_junk = 4'b0111;
    repeat (5) @(posedge clk);
    rsp_junk = '0;
    wait_log(2, 200, "stall");
    if (log_g.size() == 2) begin
      chk("stall_first_grant", 32'(log_g[0]), 3);  chk("stall_second_grant", 32'(log_g[1]), 0);
      chk("stall_rsp_cycles", 32'(log_rc[0]), 11);
      chk("stall_z0", log_z[0], 32'h40A00000);     chk("stall_z1", log_z[1], 32'h40E00000);
    end
    stall_cfg[3] = 0;

    // reset while waiting on the converter
    lat_cfg = 30;
    do_reset();
    push(0, 32'd1); push(0, 32'd9);
    wait_log(1, 200, "pre_rst");
    begin
      int c = 0;
      while (cph != 3 && c < 200) begin @(posedge clk); c++; end
    end
    @(negedge clk);
    chk("pre_rst_in_wait", 32'(cph == 3), 1);
    chk("pre_rst_busy", 32'(busy), 1);  chk("pre_rst_cvt_a", cvt_a, 32'd9);
    chk("pre_rst_z", rsp_z, 32'h3F800000);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);     chk("arst_cvt_a", cvt_a, 0);
    chk("arst_rsp_z", rsp_z, 0);        chk("arst_cnt", 32'(xfer_cnt), 0);
    chk("arst_grant", 32'(grant), 0);   chk("arst_a_stb", 32'(cvt_a_stb), 0);
    chk("arst_z_ack", 32'(cvt_z_ack), 0);
    @(posedge clk); #2 rst = 1'b0;
    lat_cfg = 1;
    log_g.delete(); log_z.delete(); log_rc.delete();
    @(posedge clk);
    push(1, 32'd3);
    wait_log(1, 100, "post_rst");
    if (log_g.size() == 1) begin
      chk("post_rst_grant", 32'(log_g[0]), 1); chk("post_rst_z", log_z[0], 32'h40400000);
    end

    // counter wrap: 17 transactions on a 4-bit counter
    do_reset();
    for (int i = 0; i < 17; i++) push(2, 32'(i + 1));
    wait_log(17, 600, "wrap");
    @(negedge clk);
    chk("wrap_cnt", 32'(xfer_cnt), 1);

    // randomized traffic against the scoreboard
    rand_cvt = 1'b1; rand_stall = 1'b1;
    do_reset();
    begin
      int total = 0;
      for (int it = 0; it < 150; it++) begin
        @(posedge clk);
        if ($urandom_range(0, 2) == 0) begin
          push(int'($urandom_range(0, N - 1)), 32'(int'($urandom_range(0, 32'h00FFFFFF)) - 32'h00800000));
          total++;
        end
      end
      wait_log(total, 4000, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/converter_i2f_arbiter.md
Name: converter_i2f_arbiter

Overview:
Round-robin arbiter that shares one converter_i2f instance among NUM_REQ requesters. It accepts a 32-bit integer from one requester and drives it through the converter's stb/ack handshake. It captures the float result and returns it to the same requester. Sits between filter-stage producers and the single shared I2F converter; one transaction in flight at a time.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
GW, 2, grant index width, equal to clog2(NUM_REQ)
CNT_W, 16, width of completed-transaction counter

Ports:
i_CLK  in  1  clock
i_RST  in  1  reset, asynchronous, active-high
i_REQ_A  in  32*NUM_REQ  packed integer operands; slice k belongs to requester k
i_REQ_STB  in  NUM_REQ  requester k operand valid; held with data stable until its ack
o_REQ_ACK  out  NUM_REQ  one-hot, operand accepted
o_RSP_Z  out  32  float result (shared bus)
o_RSP_STB  out  NUM_REQ  one-hot, result valid for requester k
i_RSP_ACK  in  NUM_REQ  requester k has taken the result
o_CVT_A  out  32  to converter i_A
o_CVT_A_STB  out  1  to converter i_A_STB
i_CVT_A_ACK  in  1  from converter o_A_ACK
i_CVT_Z  in  32  from converter o_Z
i_CVT_Z_STB  in  1  from converter o_Z_STB
o_CVT_Z_ACK  out  1  to converter i_Z_ACK
o_BUSY  out  1  high in every state except IDLE
o_GRANT  out  GW  index of current or last granted requester
o_XFER_CNT  out  CNT_W  completed transactions; wraps modulo 2^CNT_W

Behaviour:
- Every output is registered. While i_RST is high: state=IDLE, all STB/ACK outputs 0, o_RSP_Z=0, o_CVT_A=0, o_XFER_CNT=0, o_GRANT=0, r_last=NUM_REQ-1 (requester 0 wins first).
- A transfer occurs on a clock edge where the stb and ack of a pair are both 1.
- IDLE: if any i_REQ_STB is set, pick the first set bit scanning r_last+1, r_last+2, … modulo NUM_REQ. Register g into o_GRANT, latch i_REQ_A[g] into r_data, go to ACCEPT. If no bit is set, stay in IDLE.
- ACCEPT (exactly 1 cycle): o_REQ_ACK[g]=1, all other bits 0. Go to SEND.
- SEND: o_CVT_A=r_data, o_CVT_A_STB=1. On i_CVT_A_ACK=1, drop STB and go to WAIT.
- WAIT: o_CVT_Z_ACK=0. On i_CVT_Z_STB=1, latch i_CVT_Z into o_RSP_Z and go to ZACK.
- ZACK (exactly 1 cycle): o_CVT_Z_ACK=1, which completes the converter output handshake. Go to RETURN.
- RETURN: o_RSP_STB[g]=1 until i_RSP_ACK[g]=1. Then drop STB, set r_last=g, increment o_XFER_CNT, go to IDLE.
- i_RSP_ACK bits other than g are ignored. i_REQ_STB changes outside IDLE are ignored, and non-granted requesters wait.
- Minimum occupancy: converter latency + 5 cycles, assuming zero-wait acks.
- Results never reorder, because only one transaction is outstanding.
- o_RSP_Z holds its value after RETURN until the next capture.
- Reset asserted mid-transaction aborts immediately to IDLE with the reset values above. The converter shares i_RST, so no partial handshake survives.
- Requester k dropping STB before its ack violates protocol; behaviour is undefined and need not be checked.
- Fairness: a continuously requesting requester is served within NUM_REQ transactions.

Test Plan:
- Single request, requester 0, A=1 with immediate acks: one-cycle o_REQ_ACK[0]; o_RSP_Z=0x3F800000 on o_RSP_STB[0]; o_XFER_CNT=1; o_BUSY returns to 0.
- Requesters 0 and 2 assert together (A=-1 and 100): requester 0 is served first with 0xBF800000, then requester 2 with 0x42C80000; o_GRANT reads 0 then 2.
- All four requesters assert continuously (A=0, 2, 3, 1): grant order is 0,1,2,3,0,…; results are 0x00000000, 0x40000000, 0x40400000, 0x3F800000.
- Requester stalls i_RSP_ACK for 10 cycles: o_RSP_STB and o_RSP_Z stay stable; no new o_REQ_ACK is issued during the stall; acks from other bits are ignored.
- i_RST pulsed while in WAIT: all outputs return to reset values asynchronously. A fresh request from requester 1 (A=3) then completes with 0x40400000, and requester 1 is chosen after 0 by the r_last reset value.
- With CNT_W=4, run 17 transactions: o_XFER_CNT wraps to 1.
